game_flow_controller: RTL
=========================

# game_flow_controller

Sequential controller that drives the battleship game flow upstream of the game/display top level. It replaces the hand-set `game_state_code` switches with a registered state machine (idle → preparation → attack → end). In the attack phase it accepts or rejects debounced attack pulses, counts remaining shots and confirmed hits against the selected map's ship-cell count, and declares win or loss. Its `game_state_code` output feeds the top level directly. Its hit/miss result and counters feed the scoring display.

## Interface
Parameters:
- `MAX_SHOTS`, default 15: shots loaded at attack start; must fit in 5 bits, range 1–31.

Ports:
- `clk`  in  1  divided game clock, the same clock the debouncer and display counter use
- `reset`  in  1  synchronous, active-high; forces the idle state and clears all registers
- `start_pulse`  in  1  single-cycle debounced pulse from the start/advance button
- `attack_pulse`  in  1  single-cycle debounced pulse from confirm-attack
- `attack_hit`  in  1  1 = targeted cell holds a ship; valid in the same cycle as `attack_pulse`
- `attack_repeat`  in  1  1 = targeted cell was already attacked; valid in the same cycle as `attack_pulse`
- `coord_valid`  in  1  0 when x coordinate code = 7 (off-board)
- `ship_cells`  in  6  number of ship cells in the selected map; sampled on entry to ATTACK
- `game_state_code`  out  2  00 IDLE, 01 PREP, 10 ATTACK, 11 END
- `shots_left`  out  5  remaining shots
- `hits`  out  6  confirmed hits
- `win`  out  1  high in END when all ship cells were hit
- `lose`  out  1  high in END when shots ran out first
- `result_valid`  out  1  one-cycle pulse after an accepted attack
- `result_hit`  out  1  hit/miss of the most recent accepted attack

## Operation
- All outputs are registered.
- Reset values:
  - `game_state_code` = 00
  - `shots_left` = 0, `hits` = 0
  - `win` = 0, `lose` = 0
  - `result_valid` = 0, `result_hit` = 0
- IDLE:
  - `start_pulse` → PREP.
  - `attack_pulse` is ignored.
- PREP:
  - `start_pulse` → ATTACK. In the same transition: `shots_left` ← `MAX_SHOTS`, `hits` ← 0, internal `target` ← `ship_cells`.
  - If `ship_cells` = 0, go to END instead, with `win` = 1.
  - `attack_pulse` is ignored. If `start_pulse` and `attack_pulse` arrive together, `start_pulse` wins.
- ATTACK, accepted attack:
  - An attack is accepted when `attack_pulse` & `coord_valid` & !`attack_repeat`.
  - `shots_left` decrements by 1.
  - `hits` increments by 1 if `attack_hit`.
  - `result_hit` ← `attack_hit`.
  - `result_valid` pulses.
- ATTACK, rejected attack:
  - Invalid coordinate or repeated cell.
  - No counter change and no `result_valid`; `result_hit` holds.
- ATTACK, end evaluation on the post-update values:
  - If hits_next = `target` → END with `win` = 1.
  - Else if shots_next = 0 → END with `lose` = 1.
  - If the last shot is also the final hit, win has priority.
  - `start_pulse` in ATTACK is ignored.
- END:
  - Counters, `win` and `lose` hold.
  - `attack_pulse` is ignored.
  - `start_pulse` → IDLE, clearing counters, `win`, `lose` and `result_hit`.
- Arithmetic rules:
  - `hits` saturates at 63.
  - `shots_left` never decrements below 0; ATTACK is always left at 0.
  - `win` and `lose` are never high together and are 0 outside END.
- Reset at any time, including mid-ATTACK, returns to IDLE on the next edge with all reset values. Reset overrides every simultaneous pulse.

## Timing
- A pulse sampled at edge N is reflected in the registered outputs after edge N.
- State transitions, counter updates, `result_valid` and `result_hit` all appear together, one cycle after the pulse.
- `result_valid` is high for exactly one cycle per accepted attack.
- Back-to-back `attack_pulse` in consecutive cycles are each evaluated independently; no pulse is lost.
- The END transition happens in the same cycle as the final counter update. `win` or `lose` becomes visible with the last `result_valid`.
- No combinational path from any input to any output.

## Test plan
- **Reset and idle:** reset 1 cycle, then `attack_pulse` ×3 → `game_state_code` = 00, `shots_left` = 0, `hits` = 0, `result_valid` never 1.
- **Normal win:** start, then start with `ship_cells` = 3, then 3 hits → state 10 with `shots_left` = 15; after the 3rd hit `hits` = 3, `shots_left` = 12, state 11, `win` = 1, `lose` = 0.
- **Loss:** `MAX_SHOTS` = 15, `ship_cells` = 9, 15 accepted misses → `shots_left` = 0, `hits` = 0, state 11, `lose` = 1. A 16th `attack_pulse` causes no change.
- **Simultaneous last shot and final hit:** `ship_cells` = 1, 14 misses, then 1 hit → `win` = 1, `lose` = 0, `shots_left` = 0.
- **Rejections:** `attack_pulse` with `coord_valid` = 0, then with `attack_repeat` = 1 → counters unchanged, `result_valid` = 0, `result_hit` unchanged.
- **Reset mid-attack, restart, and edge cases:**
  - Reset after 5 shots → next cycle state 00, all outputs 0.
  - `start_pulse` in END → state 00.
  - `ship_cells` = 0 at start → state 11 with `win` = 1.

Source files
------------

// File: rtl/game_flow_controller.sv
// Battleship game-flow controller: idle -> preparation -> attack -> end.
// Accepts or rejects attack pulses, tracks shots/hits and declares win or loss.
module game_flow_controller #(
  parameter int MAX_SHOTS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pulse,
  input  logic       attack_pulse,
  input  logic       attack_hit,
  input  logic       attack_repeat,
  input  logic       coord_valid,
  input  logic [5:0] ship_cells,
  output logic [1:0] game_state_code,
  output logic [4:0] shots_left,
  output logic [5:0] hits,
  output logic       win,
  output logic       lose,
  output logic       result_valid,
  output logic       result_hit
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_PREP   = 2'b01;
  localparam logic [1:0] ST_ATTACK = 2'b10;
  localparam logic [1:0] ST_END    = 2'b11;

  localparam logic [4:0] LP_MAX_SHOTS = 5'(MAX_SHOTS);
  localparam logic [5:0] LP_HITS_MAX  = 6'd63;

  logic [1:0] r_state;
  logic [4:0] r_shots;
  logic [5:0] r_hits;
  logic [5:0] r_target;
  logic       r_win;
  logic       r_lose;
  logic       r_result_valid;
  logic       r_result_hit;

  logic [1:0] w_state_nxt;
  logic [4:0] w_shots_nxt;
  logic [5:0] w_hits_nxt;
  logic [5:0] w_target_nxt;
  logic       w_win_nxt;
  logic       w_lose_nxt;
  logic       w_result_valid_nxt;
  logic       w_result_hit_nxt;

  logic       w_accept;
  logic [4:0] w_shots_dec;
  logic [5:0] w_hits_inc;

  // Post-update counter values for an accepted attack; end evaluation uses these.
  always_comb begin
    w_accept    = (r_state == ST_ATTACK) & attack_pulse & coord_valid & ~attack_repeat;
    w_shots_dec = (r_shots == 5'd0) ? 5'd0 : r_shots - 5'd1;
    w_hits_inc  = (attack_hit && (r_hits != LP_HITS_MAX)) ? r_hits + 6'd1 : r_hits;
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_shots_nxt        = r_shots;
    w_hits_nxt         = r_hits;
    w_target_nxt       = r_target;
    w_win_nxt          = r_win;
    w_lose_nxt         = r_lose;
    w_result_valid_nxt = 1'b0;
    w_result_hit_nxt   = r_result_hit;

    case (r_state)
      ST_IDLE: begin
        if (start_pulse) w_state_nxt = ST_PREP;
      end
      ST_PREP: begin
        if (start_pulse) begin
          w_shots_nxt  = LP_MAX_SHOTS;
          w_hits_nxt   = 6'd0;
          w_target_nxt = ship_cells;
          // An empty map is an immediate win.
          if (ship_cells == 6'd0) begin
            w_state_nxt = ST_END;
            w_win_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_ATTACK;
          end
        end
      end
      ST_ATTACK: begin
        if (w_accept) begin
          w_shots_nxt        = w_shots_dec;
          w_hits_nxt         = w_hits_inc;
          w_result_hit_nxt   = attack_hit;
          w_result_valid_nxt = 1'b1;
          // Final hit wins even when it also consumes the last shot.
          if (w_hits_inc == r_target) begin
            w_state_nxt = ST_END;
            w_win_nxt   = 1'b1;
          end else if (w_shots_dec == 5'd0) begin
            w_state_nxt = ST_END;
            w_lose_nxt  = 1'b1;
          end
        end
      end
      ST_END: begin
        if (start_pulse) begin
          w_state_nxt      = ST_IDLE;
          w_shots_nxt      = 5'd0;
          w_hits_nxt       = 6'd0;
          w_target_nxt     = 6'd0;
          w_win_nxt        = 1'b0;
          w_lose_nxt       = 1'b0;
          w_result_hit_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_shots        <= 5'd0;
      r_hits         <= 6'd0;
      r_target       <= 6'd0;
      r_win          <= 1'b0;
      r_lose         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_hit   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_shots        <= w_shots_nxt;
      r_hits         <= w_hits_nxt;
      r_target       <= w_target_nxt;
      r_win          <= w_win_nxt;
      r_lose         <= w_lose_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_result_hit   <= w_result_hit_nxt;
    end
  end

  assign game_state_code = r_state;
  assign shots_left      = r_shots;
  assign hits            = r_hits;
  assign win             = r_win;
  assign lose            = r_lose;
  assign result_valid    = r_result_valid;
  assign result_hit      = r_result_hit;

endmodule
